osc_mix_sched: RTL and testbench
================================

Name: osc_mix_sched

Overview:
- Sample-rate scheduler and mixer that sits between the oscillator bank (sine, square, triangle, sawtooth generators) and the I2S transmitter.
- On each sample tick it polls every enabled oscillator in turn over its ready/valid handshake and accumulates the samples with signed arithmetic.
- It then applies a gain shift, saturates the result, and presents one sample to the audio output over a ready/valid handshake.
- It replaces the free-running, unsaturated oscillator sum with a controlled, overflow-safe path.

Parameters:
- width_p, 16, sample width in bits, signed two's complement.
- num_src_p, 4, number of oscillator sources.
- timeout_p, 64, maximum cycles to wait for a source's valid before skipping it.

Ports:
- clk_i  input  1  system clock (audio clock domain).
- reset_i  input  1  asynchronous, active-high reset.
- sample_tick_i  input  1  one-cycle pulse requesting a new mixed sample.
- enable_i  input  num_src_p  per-source mix enable.
- gain_shift_i  input  2  arithmetic right shift (0..3) applied to the sum before saturation.
- src_data_i  input  num_src_p*width_p  source samples; source n occupies bits [n*width_p +: width_p].
- src_valid_i  input  num_src_p  per-source valid.
- src_ready_o  output  num_src_p  per-source ready; at most one bit is set at a time.
- data_o  output  width_p  mixed, saturated sample.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts data_o.
- busy_o  output  1  high whenever the state is not IDLE.
- timeout_o  output  num_src_p  per-source timeout flags; cleared at the start of each sample.
- overrun_o  output  1  sticky: a tick arrived while busy; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high; also applies mid-operation):
  - state=IDLE, idx=0, acc=0, wait counter=0.
  - data_o=0, valid_o=0, src_ready_o=0, busy_o=0, timeout_o=0, overrun_o=0.
- Accumulator width: acc_w = width_p + clog2(num_src_p), i.e. 18 bits at the defaults.
  - Each accepted sample is sign-extended to acc_w before it is added.
- State machine:
  - IDLE: on sample_tick_i, clear acc, idx and timeout_o, then go to POLL.
  - POLL, enable_i[idx]=0: skip in one cycle; no ready is asserted.
  - POLL, enable_i[idx]=1: drive src_ready_o[idx]=1, all other ready bits 0.
    - Handshake when src_valid_i[idx] && src_ready_o[idx]: acc += sext(src_data_i[idx]); advance.
    - If the wait counter reaches timeout_p-1 with valid still low: set timeout_o[idx], add 0, advance.
  - Advance: reset the wait counter. If idx==num_src_p-1 go to SAT, else idx++.
  - SAT: compute s = acc >>> gain_shift_i (arithmetic shift).
    - If s > 2^(width_p-1)-1, load 0x7FFF (for width_p=16).
    - If s < -2^(width_p-1), load 0x8000.
    - Otherwise load s[width_p-1:0].
    - The result is registered into data_o; go to OUT.
  - OUT: valid_o=1 and data_o held stable until ready_i. On the ready_i && valid_o handshake, go to IDLE with valid_o=0 in the next cycle.
- Latency: tick sampled at edge k; all enabled sources valid immediately.
  - valid_o rises at edge k+num_src_p+2 (k+6 at the defaults).
  - Disabled sources also cost one cycle each, so latency is fixed.
- sample_tick_i while busy_o=1 (including in OUT): the tick is dropped, overrun_o is set, and the in-flight sample is unaffected.
- sample_tick_i in the same cycle as the OUT handshake completes: counts as an overrun (the state is not yet IDLE), and the tick is dropped.
- enable_i and gain_shift_i are sampled live; changing them mid-sample affects only the sources and shift not yet processed.
- src_data_i is sampled only on the handshake cycle.

Test Plan:
- enable=4'hF, shift=0, all sources 0x1000, valid held high, tick at k -> data_o=0x4000, valid_o rises at k+6, src_ready_o one-hot 0001,0010,0100,1000 in k+1..k+4.
- All sources 0x7FFF, shift=0 -> 0x7FFF (saturated). Same inputs with shift=2 -> 0x7FFF (0x1FFFC>>>2). All sources 0x8000, shift=0 -> 0x8000.
- enable=4'b0010, src1=0x0123, src0 holds 0x7FFF -> data_o=0x0123 at k+6; src_ready_o[0,2,3] never asserted.
- enable=4'hF, src2 valid stuck low, others 0x0100 -> src_ready_o[2] high for exactly 64 cycles, timeout_o=4'b0100, data_o=0x0300.
- ready_i held low in OUT, second tick pulsed -> overrun_o=1, data_o unchanged; after ready_i=1 -> IDLE, overrun_o stays 1 until reset.
- reset_i asserted during POLL idx=2 -> same cycle: src_ready_o=0, valid_o=0, busy_o=0. After release, the next tick yields a correct full mix.

Source files
------------

// File: rtl/osc_mix_sched.sv
`default_nettype none
// ============================================================================
//  Module   : osc_mix_sched
//  Summary  : Per-tick oscillator poller and signed mixer with gain shift,
//             saturation and a ready/valid sample output.
//  Revision : 1.0 - initial release
// ============================================================================
module osc_mix_sched #(
    parameter int width_p   = 16,
    parameter int num_src_p = 4,
    parameter int timeout_p = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           sample_tick_i,
    input  logic [num_src_p-1:0]           enable_i,
    input  logic [1:0]                     gain_shift_i,
    input  logic [num_src_p*width_p-1:0]   src_data_i,
    input  logic [num_src_p-1:0]           src_valid_i,
    output logic [num_src_p-1:0]           src_ready_o,
    output logic [width_p-1:0]             data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           busy_o,
    output logic [num_src_p-1:0]           timeout_o,
    output logic                           overrun_o
);

    localparam int c_idx_w = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int c_acc_w = width_p + $clog2(num_src_p);
    localparam int c_cnt_w = (timeout_p > 1) ? $clog2(timeout_p) : 1;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(num_src_p - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(timeout_p - 1);

    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w - width_p + 1){1'b0}}, {(width_p - 1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min = ~c_sat_max;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_poll = 2'd1;
    localparam logic [1:0] c_st_sat  = 2'd2;
    localparam logic [1:0] c_st_out  = 2'd3;

    logic [1:0]                  r_state,   w_state_nxt;
    logic [c_idx_w-1:0]          r_idx,     w_idx_nxt;
    logic signed [c_acc_w-1:0]   r_acc,     w_acc_nxt;
    logic [c_cnt_w-1:0]          r_cnt,     w_cnt_nxt;
    logic [width_p-1:0]          r_data,    w_data_nxt;
    logic [num_src_p-1:0]        r_timeout, w_timeout_nxt;
    logic                        r_overrun, w_overrun_nxt;
    logic [num_src_p-1:0]        w_src_ready;
    logic                        w_advance;

    logic signed [width_p-1:0]   w_src_arr [num_src_p];
    logic signed [c_acc_w-1:0]   w_sext;
    logic signed [c_acc_w-1:0]   w_shifted;
    logic [width_p-1:0]          w_sat_val;

    for (genvar n = 0; n < num_src_p; n++) begin : g_unpack
        assign w_src_arr[n] = src_data_i[n*width_p +: width_p];
    end

    assign w_sext    = c_acc_w'(w_src_arr[r_idx]);
    assign w_shifted = r_acc >>> gain_shift_i;

    always_comb begin
        w_sat_val = w_shifted[width_p-1:0];
        if (w_shifted > c_sat_max) begin
            w_sat_val = {1'b0, {(width_p - 1){1'b1}}};
        end else if (w_shifted < c_sat_min) begin
            w_sat_val = {1'b1, {(width_p - 1){1'b0}}};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_data_nxt    = r_data;
        w_timeout_nxt = r_timeout;
        // A tick can only be honoured from IDLE; anywhere else it is an overrun.
        w_overrun_nxt = r_overrun | (sample_tick_i && (r_state != c_st_idle));
        w_src_ready   = '0;
        w_advance     = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (sample_tick_i) begin
                    w_acc_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = '0;
                    w_state_nxt   = c_st_poll;
                end
            end
            c_st_poll: begin
                if (!enable_i[r_idx]) begin
                    w_advance = 1'b1;
                end else begin
                    w_src_ready[r_idx] = 1'b1;
                    if (src_valid_i[r_idx]) begin
                        w_acc_nxt = r_acc + w_sext;
                        w_advance = 1'b1;
                    end else if (r_cnt == c_cnt_last) begin
                        w_timeout_nxt[r_idx] = 1'b1;
                        w_advance            = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                if (w_advance) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = c_st_sat;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            c_st_sat: begin
                w_data_nxt  = w_sat_val;
                w_state_nxt = c_st_out;
            end
            c_st_out: begin
                if (ready_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_timeout <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data    <= w_data_nxt;
            r_timeout <= w_timeout_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign src_ready_o = w_src_ready;
    assign data_o      = r_data;
    assign valid_o     = (r_state == c_st_out);
    assign busy_o      = (r_state != c_st_idle);
    assign timeout_o   = r_timeout;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_osc_mix_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osc_mix_sched
//  Summary  : Self-checking bench for osc_mix_sched against a sum/shift/clamp
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_osc_mix_sched;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        sample_tick_i;
    logic [3:0]  enable_i;
    logic [1:0]  gain_shift_i;
    logic [63:0] src_data_i;
    logic [3:0]  src_valid_i;
    logic [3:0]  src_ready_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic [3:0]  timeout_o;
    logic        overrun_o;

    logic [15:0] sdata [4];
    logic [3:0]  stuck;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_mix for one sample
    logic [3:0]  trace [0:7];
    int          rdy_cnt [4];
    logic [3:0]  rdy_seen;
    logic        onehot_ok;
    int          lat;
    logic [15:0] got;

    always #5 clk = ~clk;

    assign src_data_i  = {sdata[3], sdata[2], sdata[1], sdata[0]};
    assign src_valid_i = ~stuck;

    osc_mix_sched #(.width_p(16), .num_src_p(4), .timeout_p(64)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .sample_tick_i (sample_tick_i),
        .enable_i      (enable_i),
        .gain_shift_i  (gain_shift_i),
        .src_data_i    (src_data_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .overrun_o     (overrun_o)
    );

    function automatic logic [15:0] ref_mix(input logic [3:0] en, input logic [3:0] stk,
                                            input int sh);
        int sum = 0;
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            if (en[i] && !stk[i]) sum += int'($signed(sdata[i]));
        sum = sum >>> sh;
        if (sum > 32767)       r = 16'h7FFF;
        else if (sum < -32768) r = 16'h8000;
        else                   r = sum[15:0];
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] en, input logic [3:0] stk);
        return 6 + 63 * $countones(en & stk);
    endfunction

    task automatic handshake();
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
    endtask

    // Pulse a tick, then sample once per cycle on the falling edge; lat==j means
    // the value present at rising edge k+j after the tick edge k.
    task automatic run_mix(input bit finish_hs);
        logic got_valid;
        @(negedge clk);
        sample_tick_i = 1'b1;
        @(posedge clk);
        #1 sample_tick_i = 1'b0;
        lat = 0; rdy_seen = '0; onehot_ok = 1'b1; got_valid = 1'b0;
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        for (int i = 0; i < 8; i++) trace[i] = '0;
        while (lat < 400 && !got_valid) begin
            @(negedge clk);
            lat++;
            if (lat < 8) trace[lat] = src_ready_o;
            rdy_seen |= src_ready_o;
            for (int i = 0; i < 4; i++) if (src_ready_o[i]) rdy_cnt[i]++;
            if ($countones(src_ready_o) > 1) onehot_ok = 1'b0;
            if (valid_o) got_valid = 1'b1;
        end
        if (!got_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: valid_o low after %0d cycles, required high", lat);
        end
        got = data_o;
        if (finish_hs) handshake();
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        checks++; if (src_ready_o !== 4'h0) begin errors++; $display("FAIL rst_ready: got %b want 0000", src_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        checks++; if (timeout_o !== 4'h0) begin errors++; $display("FAIL rst_timeout: got %b want 0000", timeout_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_basic_mix();
        logic [3:0] exp_tr;
        enable_i = 4'hF; gain_shift_i = 2'd0; stuck = 4'h0;
        for (int i = 0; i < 4; i++) sdata[i] = 16'h1000;
        run_mix(1'b1);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL basic_data: got %h want 4000", got); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", lat); end
        for (int j = 1; j <= 4; j++) begin
            exp_tr = 4'b0001 << (j - 1);
            checks++;
            if (trace[j] !== exp_tr) begin
                errors++; $display("FAIL basic_ready_k%0d: got %b want %b", j, trace[j], exp_tr);
            end
        end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_idle: busy %b valid %b want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vals [3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
        logic [1:0]  shs  [3] = '{2'd0, 2'd2, 2'd0};
        logic [15:0] exps [3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
        enable_i = 4'hF; stuck = 4'h0;
        for (int t = 0; t < 3; t++) begin
            gain_shift_i = shs[t];
            for (int i = 0; i < 4; i++) sdata[i] = vals[t];
            run_mix(1'b1);
            checks++;
            if (got !== exps[t]) begin
                errors++; $display("FAIL sat_%0d: got %h want %h", t, got, exps[t]);
            end
        end
    endtask

    task automatic test_enable_mask();
        enable_i = 4'b0010; gain_shift_i = 2'd0; stuck = 4'h0;
        sdata[0] = 16'h7FFF; sdata[1] = 16'h0123; sdata[2] = 16'h4444; sdata[3] = 16'h5555;
        run_mix(1'b1);
        checks++; if (got !== 16'h0123) begin errors++; $display("FAIL mask_data: got %h want 0123", got); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL mask_latency: got %0d want 6", lat); end
        checks++; if (rdy_seen !== 4'b0010) begin errors++; $display("FAIL mask_ready: got %b want 0010", rdy_seen); end
    endtask

    task automatic test_timeout();
        enable_i = 4'hF; gain_shift_i = 2'd0; stuck = 4'b0100;
        for (int i = 0; i < 4; i++) sdata[i] = 16'h0100;
        run_mix(1'b1);
        checks++; if (got !== 16'h0300) begin errors++; $display("FAIL to_data: got %h want 0300", got); end
        checks++; if (rdy_cnt[2] !== 64) begin errors++; $display("FAIL to_ready_cycles: got %0d want 64", rdy_cnt[2]); end
        checks++; if (timeout_o !== 4'b0100) begin errors++; $display("FAIL to_flags: got %b want 0100", timeout_o); end
        checks++; if (lat !== 69) begin errors++; $display("FAIL to_latency: got %0d want 69", lat); end
        checks++; if (!onehot_ok) begin errors++; $display("FAIL to_onehot: got multi-hot ready want one-hot"); end
        stuck = 4'h0;
    endtask

    task automatic test_overrun();
        logic [15:0] held;
        enable_i = 4'hF; gain_shift_i = 2'd1; stuck = 4'h0;
        sdata[0] = 16'h0200; sdata[1] = 16'h0400; sdata[2] = 16'hFF00; sdata[3] = 16'h0002;
        run_mix(1'b0);
        held = got;
        checks++; if (held !== ref_mix(4'hF, 4'h0, 1)) begin
            errors++; $display("FAIL ovr_first: got %h want %h", held, ref_mix(4'hF, 4'h0, 1));
        end
        sample_tick_i = 1'b1;
        @(posedge clk);
        #1 sample_tick_i = 1'b0;
        @(negedge clk);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
        checks++; if (valid_o !== 1'b1 || data_o !== held) begin
            errors++; $display("FAIL ovr_hold: valid %b data %h want 1 %h", valid_o, data_o, held);
        end
        // Tick coincident with the output handshake must be dropped
        sample_tick_i = 1'b1; ready_i = 1'b1;
        @(posedge clk);
        #1 sample_tick_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL ovr_hs_tick: busy %b valid %b want 0 0", busy_o, valid_o);
        end
        run_mix(1'b1);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
        checks++; if (got !== ref_mix(4'hF, 4'h0, 1)) begin
            errors++; $display("FAIL ovr_next: got %h want %h", got, ref_mix(4'hF, 4'h0, 1));
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        enable_i = 4'hF; gain_shift_i = 2'd0; stuck = 4'h0;
        for (int i = 0; i < 4; i++) sdata[i] = 16'h0111;
        @(negedge clk);
        sample_tick_i = 1'b1;
        @(posedge clk);
        #1 sample_tick_i = 1'b0;
        @(negedge clk);
        while (src_ready_o !== 4'b0100 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (src_ready_o !== 4'b0100) begin errors++; $display("FAIL mid_reach_idx2: got %b want 0100", src_ready_o); end
        reset_i = 1'b1;
        #1;
        checks++; if (src_ready_o !== 4'h0 || valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset: ready %b valid %b busy %b ovr %b want 0000 0 0 0",
                               src_ready_o, valid_o, busy_o, overrun_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        run_mix(1'b1);
        checks++; if (got !== 16'h0444 || lat !== 6) begin
            errors++; $display("FAIL mid_after: data %h lat %0d want 0444 6", got, lat);
        end
    endtask

    task automatic test_random();
        logic [3:0] en;
        logic [1:0] sh;
        logic [15:0] exp_d;
        for (int n = 0; n < 25; n++) begin
            en = 4'($urandom); sh = 2'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: sdata[i] = 16'h7FFF;
                    1: sdata[i] = 16'h8000;
                    default: sdata[i] = 16'($urandom);
                endcase
                stuck[i] = ($urandom_range(0, 5) == 0);
            end
            enable_i = en; gain_shift_i = sh;
            exp_d = ref_mix(en, stuck, int'(sh));
            run_mix(1'b1);
            checks++; if (got !== exp_d) begin
                errors++; $display("FAIL rand%0d_data: got %h want %h", n, got, exp_d);
            end
            checks++; if (timeout_o !== (en & stuck)) begin
                errors++; $display("FAIL rand%0d_timeout: got %b want %b", n, timeout_o, en & stuck);
            end
            checks++; if (lat !== ref_lat(en, stuck) || rdy_seen !== en || !onehot_ok) begin
                errors++; $display("FAIL rand%0d_timing: lat %0d ready %b want %0d %b one-hot",
                                   n, lat, rdy_seen, ref_lat(en, stuck), en);
            end
        end
        stuck = 4'h0;
    endtask

    initial begin
        reset_i = 1'b1; sample_tick_i = 1'b0; ready_i = 1'b0;
        enable_i = 4'h0; gain_shift_i = 2'd0; stuck = 4'h0;
        for (int i = 0; i < 4; i++) sdata[i] = 16'h0;
        test_reset();
        test_basic_mix();
        test_saturation();
        test_enable_mask();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
